// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: circular buffer with FWFT valid/ready read port.
// Define UART_RX_FIFO_ERR_FLAGS_EN to store parity/stop error flags per byte.
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              parity_err_i,
  input  logic              stop_err_i,
  input  logic              flush_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        rd_err_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(DEPTH);

`ifdef UART_RX_FIFO_ERR_FLAGS_EN
  localparam int MW = DATA_W + 2;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0]    mem [DEPTH];
  logic [MW-1:0]    wr_word;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             empty_q;
  logic             full_q;
  logic             afull_q;
  logic             ovf_q;
  logic             pop;
  logic             push_ok;

`ifdef UART_RX_FIFO_ERR_FLAGS_EN
  assign wr_word  = {parity_err_i, stop_err_i, wr_data_i};
  assign rd_err_o = mem[rd_ptr][DATA_W+1:DATA_W];
`else
  logic unused_err;
  assign unused_err = parity_err_i ^ stop_err_i;
  assign wr_word    = wr_data_i;
  assign rd_err_o   = 2'b00;
`endif

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop     = !empty_q && rd_ready_i;
  assign push_ok = push_i && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_i && !push_ok) begin
        ovf_q <= 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      afull_q <= (count_d >= CNT_W'(AFULL_LVL));
    end
  end

  assign rd_valid_o = !empty_q;
  assign rd_data_o  = mem[rd_ptr][DATA_W-1:0];
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign afull_o    = afull_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: queue reference model checked every cycle,
// plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push;
  logic [7:0] wr_data;
  logic       perr;
  logic       serr;
  logic       flush;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [1:0] rd_err;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       afull;
  logic       ovf;

  int n_vec  = 0;
  int n_fail = 0;

  logic [9:0] mq[$];
  logic       m_ovf;

  uart_rx_fifo #(
    .DATA_W(8),
    .DEPTH(DEPTH),
    .AFULL_LVL(AFULL)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .push_i(push),
    .wr_data_i(wr_data),
    .parity_err_i(perr),
    .stop_err_i(serr),
    .flush_i(flush),
    .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready),
    .rd_data_o(rd_data),
    .rd_err_o(rd_err),
    .count_o(count),
    .empty_o(empty),
    .full_o(full),
    .afull_o(afull),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte queue with drop-on-full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd_ready && mq.size() > 0) begin
        void'(mq.pop_front());
      end
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back({perr, serr, wr_data});
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("count", int'(count), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == DEPTH));
    chk("afull", int'(afull), int'(sz >= AFULL));
    chk("rd_valid", int'(rd_valid), int'(sz != 0));
    chk("overflow", int'(ovf), int'(m_ovf));
    if (sz != 0) begin
      chk("rd_data", int'(rd_data), int'(mq[0][7:0]));
    end
`ifdef UART_RX_FIFO_ERR_FLAGS_EN
    if (sz != 0) chk("rd_err", int'(rd_err), int'(mq[0][9:8]));
`else
    chk("rd_err", int'(rd_err), 0);
`endif
  end

  // Drive one cycle of inputs, then land 1 time unit past the edge.
  task automatic step(input logic p, input logic [7:0] d,
                      input logic r, input logic f);
    push     = p;
    wr_data  = d;
    rd_ready = r;
    flush    = f;
    @(posedge clk);
    #1;
    push  = 1'b0;
    flush = 1'b0;
    perr  = 1'b0;
    serr  = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    push     = 1'b0;
    wr_data  = '0;
    perr     = 1'b0;
    serr     = 1'b0;
    flush    = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_ovf", int'(ovf), 0);

    step(1, 8'h41, 0, 0);
    chk("lat_valid", int'(rd_valid), 1);
    step(1, 8'h42, 0, 0);
    step(1, 8'h43, 0, 0);
    chk("cnt3", int'(count), 3);
    chk("head41", int'(rd_data), 'h41);
    for (int i = 0; i < 3; i++) begin
      chk("pop_abc", int'(rd_data), 'h41 + i);
      step(0, 8'h00, 1, 0);
    end
    chk("abc_empty", int'(empty), 1);
    step(0, 8'h00, 1, 0);
    chk("rdy_empty", int'(count), 0);

    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 10) chk("afull11", int'(afull), 0);
      if (i == 11) chk("afull12", int'(afull), 1);
      if (i == 14) chk("full15", int'(full), 0);
    end
    chk("full16", int'(full), 1);
    step(1, 8'hFF, 0, 0);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_cnt", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain", int'(rd_data), i);
      step(0, 8'h00, 1, 0);
    end
    chk("drain_empty", int'(empty), 1);
    chk("ovf_sticky", int'(ovf), 1);
    step(0, 8'h00, 0, 1);
    chk("ovf_clr", int'(ovf), 0);

    for (int i = 0; i < 16; i++) step(1, 8'h10 + 8'(i), 0, 0);
    step(1, 8'hAA, 1, 0);
    chk("fp_cnt", int'(count), 16);
    chk("fp_ovf", int'(ovf), 0);
    for (int i = 0; i < 16; i++) begin
      chk("fp_drain", int'(rd_data), (i == 15) ? 'hAA : 'h11 + i);
      step(0, 8'h00, 1, 0);
    end

    for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      chk("wrap_head", int'(rd_data), (i < 3) ? 'h60 + i : 'h80 + i - 3);
      step(1, 8'h80 + 8'(i), 1, 0);
      chk("wrap_cnt", int'(count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      chk("wrap_tail", int'(rd_data), 'h80 + 37 + i);
      step(0, 8'h00, 1, 0);
    end

    for (int i = 0; i < 7; i++) step(1, 8'h30 + 8'(i), 0, 0);
    chk("cnt7", int'(count), 7);
    step(1, 8'h99, 0, 1);
    chk("fl_cnt", int'(count), 0);
    chk("fl_empty", int'(empty), 1);
    step(0, 8'h00, 0, 0);
    chk("fl_valid", int'(rd_valid), 0);

    for (int i = 0; i < 5; i++) step(1, 8'h70 + 8'(i), 0, 0);
    chk("cnt5", int'(count), 5);
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", int'(count), 0);
    chk("ar_empty", int'(empty), 1);
    chk("ar_valid", int'(rd_valid), 0);
    chk("ar_full", int'(full), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0);

    perr = 1'b1;
    step(1, 8'h55, 0, 0);
    chk("err_data", int'(rd_data), 'h55);
`ifdef UART_RX_FIFO_ERR_FLAGS_EN
    chk("err_flags", int'(rd_err), 2);
`else
    chk("err_flags", int'(rd_err), 0);
`endif
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
